wb_master_arbiter: RTL and testbench

- Round-robin arbiter sharing one Wishbone master port between N requesting masters, e.g. instruction fetch, data LSU and debug.
- Sits in front of wb_compressor, which serialises onto the cw_* bus.
- Holds a grant for the whole wb_cyc of the owning master, so 4- and 8-beat bursts are never split.
- Routes ack/err back to the owner only, and adds a watchdog that errors out stalled transfers.

---
 rtl/wb_master_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_master_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between N_M masters.
// The grant is held for the owner's whole cycle, and a watchdog errors out stalled strobes.
module wb_master_arbiter #(
  parameter int N_M     = 2,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_M-1:0]        m_cyc,
  input  logic [N_M-1:0]        m_stb,
  input  logic [N_M*ADDR_W-1:0] m_adr,
  input  logic [N_M*DATA_W-1:0] m_o_dat,
  input  logic [N_M-1:0]        m_we,
  input  logic [N_M*2-1:0]      m_sel,
  input  logic [N_M-1:0]        m_8_burst,
  input  logic [N_M-1:0]        m_4_burst,
  output logic [DATA_W-1:0]     m_i_dat,
  output logic [N_M-1:0]        m_ack,
  output logic [N_M-1:0]        m_err,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic [ADDR_W-1:0]     s_adr,
  output logic [DATA_W-1:0]     s_o_dat,
  output logic                  s_we,
  output logic [1:0]            s_sel,
  output logic                  s_8_burst,
  output logic                  s_4_burst,
  input  logic [DATA_W-1:0]     s_i_dat,
  input  logic                  s_ack,
  input  logic                  s_err,
  output logic [N_M-1:0]        o_grant,
  output logic                  o_busy
);

  localparam int          IDX_W = (N_M > 2) ? 2 : 1;
  localparam int unsigned NM_U  = N_M;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, r_last, w_win, w_scan;
  logic [7:0]       r_wait, w_wait_nxt;
  logic [N_M-1:0]   w_req;
  logic             w_req_any;
  logic             w_own_cyc;
  logic             w_stb;
  logic             w_wd;

  assign w_req     = m_cyc & m_stb;
  assign w_own_cyc = m_cyc[r_owner];
  assign w_stb     = (r_state == BUSY) && w_own_cyc && m_stb[r_owner];
  // An ack landing in the timeout cycle suppresses the watchdog pulse.
  assign w_wd      = (TIMEOUT != 0) && w_stb && !s_ack && (r_wait == 8'(TIMEOUT));
  assign m_i_dat   = s_i_dat;

  // Scan starts just after the last owner, giving round-robin priority.
  always_comb begin
    w_win     = '0;
    w_scan    = '0;
    w_req_any = 1'b0;
    for (int unsigned i = 1; i <= NM_U; i++) begin
      w_scan = IDX_W'((32'(r_last) + i) % NM_U);
      if (!w_req_any && w_req[w_scan]) begin
        w_req_any = 1'b1;
        w_win     = w_scan;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_any) w_state_nxt = BUSY;
      BUSY:    if (!w_own_cyc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wait_nxt = '0;
    if (w_stb && !s_ack && !s_err && !w_wd && (r_wait != 8'hFF))
      w_wait_nxt = r_wait + 8'd1;
    else if (w_stb && !s_ack && !s_err && !w_wd)
      w_wait_nxt = r_wait;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(N_M - 1);
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (r_state == IDLE && w_req_any) begin
        r_owner <= w_win;
        r_last  <= w_win;
      end
    end
  end

  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_adr     = '0;
    s_o_dat   = '0;
    s_we      = 1'b0;
    s_sel     = '0;
    s_8_burst = 1'b0;
    s_4_burst = 1'b0;
    o_grant   = '0;
    o_busy    = 1'b0;
    m_ack     = '0;
    m_err     = '0;
    if (r_state == BUSY) begin
      s_cyc            = w_own_cyc;
      s_stb            = w_stb;
      s_adr            = m_adr[r_owner*ADDR_W +: ADDR_W];
      s_o_dat          = m_o_dat[r_owner*DATA_W +: DATA_W];
      s_we             = m_we[r_owner];
      s_sel            = m_sel[r_owner*2 +: 2];
      s_8_burst        = m_8_burst[r_owner];
      s_4_burst        = m_4_burst[r_owner];
      o_grant[r_owner] = 1'b1;
      o_busy           = 1'b1;
      m_ack[r_owner]   = s_ack & m_stb[r_owner];
      m_err[r_owner]   = s_err | w_wd;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: a vector table for arbitration and routing,
// plus hand-written sequences for bursts, watchdog timing and mid-transfer reset.
module tb_wb_master_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [1:0]  m_cyc, m_stb, m_we, m_8_burst, m_4_burst;
  logic [47:0] m_adr;
  logic [31:0] m_o_dat;
  logic [3:0]  m_sel;
  logic [15:0] m_i_dat;
  logic [1:0]  m_ack, m_err;
  logic        s_cyc, s_stb, s_we, s_8_burst, s_4_burst;
  logic [23:0] s_adr;
  logic [15:0] s_o_dat;
  logic [1:0]  s_sel;
  logic [15:0] s_i_dat;
  logic        s_ack, s_err;
  logic [1:0]  o_grant;
  logic        o_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_master_arbiter #(.N_M(2), .ADDR_W(24), .DATA_W(16), .TIMEOUT(10)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_adr(m_adr), .m_o_dat(m_o_dat),
    .m_we(m_we), .m_sel(m_sel), .m_8_burst(m_8_burst), .m_4_burst(m_4_burst),
    .m_i_dat(m_i_dat), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_adr(s_adr), .s_o_dat(s_o_dat),
    .s_we(s_we), .s_sel(s_sel), .s_8_burst(s_8_burst), .s_4_burst(s_4_burst),
    .s_i_dat(s_i_dat), .s_ack(s_ack), .s_err(s_err),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst_n;
    logic [1:0]  cyc, stb;
    logic        ack, err;
    logic [15:0] idat;
    logic        e_scyc, e_sstb;
    logic [23:0] e_adr;
    logic [15:0] e_dat;
    logic        e_we;
    logic [1:0]  e_grant, e_ack, e_err;
    logic        e_busy;
  } vec_t;

  localparam logic [23:0] A0 = 24'h123456;
  localparam logic [23:0] A1 = 24'h00ABCD;
  localparam logic [15:0] D0 = 16'hBEEF;
  localparam logic [15:0] D1 = 16'h1234;

  vec_t tbl [20];

  function automatic vec_t mk(input logic rst_n, input logic [1:0] cyc, stb,
                              input logic ack, err, input logic [15:0] idat,
                              input logic scyc, sstb, input logic [23:0] adr,
                              input logic [15:0] dat, input logic we,
                              input logic [1:0] grant, mack, merr, input logic busy);
    vec_t v;
    v.rst_n = rst_n; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.idat = idat;
    v.e_scyc = scyc; v.e_sstb = sstb; v.e_adr = adr; v.e_dat = dat; v.e_we = we;
    v.e_grant = grant; v.e_ack = mack; v.e_err = merr; v.e_busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic [1:0] cyc, stb,
                       input logic ack, err, input logic [15:0] idat);
    i_rst_n = rst_n; m_cyc = cyc; m_stb = stb;
    s_ack = ack; s_err = err; s_i_dat = idat;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    m_adr = {A1, A0};
    m_o_dat = {D1, D0};
    m_we = 2'b01;
    m_sel = {2'b10, 2'b11};
    m_8_burst = 2'b00;
    m_4_burst = 2'b00;

    //               rst cyc    stb    ack  err  idat      scyc sstb adr   dat  we   grant  ack    err    busy
    tbl[0]  = mk(1, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, 24'h0, 16'h0, 0, 2'b00, 2'b00, 2'b00, 0);
    tbl[1]  = mk(1, 2'b01, 2'b01, 0, 0, 16'h0000, 0, 0, 24'h0, 16'h0, 0, 2'b00, 2'b00, 2'b00, 0);
    tbl[2]  = mk(1, 2'b01, 2'b01, 0, 0, 16'h0000, 1, 1, A0,    D0,    1, 2'b01, 2'b00, 2'b00, 1);
    tbl[3]  = mk(1, 2'b01, 2'b01, 1, 0, 16'h5A5A, 1, 1, A0,    D0,    1, 2'b01, 2'b01, 2'b00, 1);
    tbl[4]  = mk(1, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, A0,    D0,    1, 2'b01, 2'b00, 2'b00, 1);
    tbl[5]  = mk(0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, 24'h0, 16'h0, 0, 2'b00, 2'b00, 2'b00, 0);
    tbl[6]  = mk(1, 2'b11, 2'b11, 0, 0, 16'h0000, 0, 0, 24'h0, 16'h0, 0, 2'b00, 2'b00, 2'b00, 0);
    tbl[7]  = mk(1, 2'b11, 2'b11, 1, 0, 16'h1111, 1, 1, A0,    D0,    1, 2'b01, 2'b01, 2'b00, 1);
    tbl[8]  = mk(1, 2'b10, 2'b10, 0, 0, 16'h0000, 0, 0, A0,    D0,    1, 2'b01, 2'b00, 2'b00, 1);
    tbl[9]  = mk(1, 2'b11, 2'b11, 0, 0, 16'h0000, 0, 0, 24'h0, 16'h0, 0, 2'b00, 2'b00, 2'b00, 0);
    tbl[10] = mk(1, 2'b11, 2'b11, 1, 0, 16'h2222, 1, 1, A1,    D1,    0, 2'b10, 2'b10, 2'b00, 1);
    tbl[11] = mk(1, 2'b01, 2'b01, 0, 1, 16'h0000, 0, 0, A1,    D1,    0, 2'b10, 2'b00, 2'b10, 1);
    tbl[12] = mk(1, 2'b11, 2'b11, 0, 0, 16'h0000, 0, 0, 24'h0, 16'h0, 0, 2'b00, 2'b00, 2'b00, 0);
    tbl[13] = mk(1, 2'b11, 2'b11, 1, 0, 16'h3333, 1, 1, A0,    D0,    1, 2'b01, 2'b01, 2'b00, 1);
    tbl[14] = mk(1, 2'b10, 2'b10, 0, 0, 16'h0000, 0, 0, A0,    D0,    1, 2'b01, 2'b00, 2'b00, 1);
    tbl[15] = mk(1, 2'b11, 2'b11, 0, 0, 16'h0000, 0, 0, 24'h0, 16'h0, 0, 2'b00, 2'b00, 2'b00, 0);
    tbl[16] = mk(1, 2'b11, 2'b11, 0, 1, 16'h0000, 1, 1, A1,    D1,    0, 2'b10, 2'b00, 2'b10, 1);
    tbl[17] = mk(1, 2'b11, 2'b11, 1, 0, 16'h4444, 1, 1, A1,    D1,    0, 2'b10, 2'b10, 2'b00, 1);
    tbl[18] = mk(1, 2'b01, 2'b01, 0, 0, 16'h0000, 0, 0, A1,    D1,    0, 2'b10, 2'b00, 2'b00, 1);
    tbl[19] = mk(1, 2'b00, 2'b00, 1, 1, 16'h7777, 0, 0, 24'h0, 16'h0, 0, 2'b00, 2'b00, 2'b00, 0);

    drive(0, 2'b00, 2'b00, 0, 0, 16'h0);
    tick();
    tick();

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].rst_n, tbl[r].cyc, tbl[r].stb, tbl[r].ack, tbl[r].err, tbl[r].idat);
      chk($sformatf("row%0d s_cyc", r),   32'(s_cyc),   32'(tbl[r].e_scyc));
      chk($sformatf("row%0d s_stb", r),   32'(s_stb),   32'(tbl[r].e_sstb));
      chk($sformatf("row%0d s_adr", r),   32'(s_adr),   32'(tbl[r].e_adr));
      chk($sformatf("row%0d s_o_dat", r), 32'(s_o_dat), 32'(tbl[r].e_dat));
      chk($sformatf("row%0d s_we", r),    32'(s_we),    32'(tbl[r].e_we));
      chk($sformatf("row%0d o_grant", r), 32'(o_grant), 32'(tbl[r].e_grant));
      chk($sformatf("row%0d m_ack", r),   32'(m_ack),   32'(tbl[r].e_ack));
      chk($sformatf("row%0d m_err", r),   32'(m_err),   32'(tbl[r].e_err));
      chk($sformatf("row%0d o_busy", r),  32'(o_busy),  32'(tbl[r].e_busy));
      chk($sformatf("row%0d m_i_dat", r), 32'(m_i_dat), 32'(tbl[r].idat));
      tick();
    end

    // 8-beat burst owned by m1 while m0 waits
    drive(0, 2'b00, 2'b00, 0, 0, 16'h0);
    tick();
    m_8_burst = 2'b10;
    drive(1, 2'b10, 2'b10, 0, 0, 16'h0);
    chk("burst8 idle grant", 32'(o_grant), 32'h0);
    tick();
    for (int b = 0; b < 8; b++) begin
      drive(1, (b == 0) ? 2'b10 : 2'b11, (b == 0) ? 2'b10 : 2'b11, 1, 0, 16'hC000 + 16'(b));
      chk($sformatf("burst8 beat%0d grant", b), 32'(o_grant), 32'h2);
      chk($sformatf("burst8 beat%0d ack", b),   32'(m_ack),   32'h2);
      chk($sformatf("burst8 beat%0d err", b),   32'(m_err),   32'h0);
      chk($sformatf("burst8 beat%0d idat", b),  32'(m_i_dat), 32'hC000 + 32'(b));
      chk($sformatf("burst8 beat%0d flag", b),  32'(s_8_burst), 32'h1);
      tick();
    end
    drive(1, 2'b01, 2'b01, 0, 0, 16'h0);
    chk("burst8 release grant", 32'(o_grant), 32'h2);
    chk("burst8 release s_cyc", 32'(s_cyc), 32'h0);
    tick();
    drive(1, 2'b01, 2'b01, 0, 0, 16'h0);
    chk("burst8 gap grant", 32'(o_grant), 32'h0);
    chk("burst8 gap s_cyc", 32'(s_cyc), 32'h0);
    tick();
    drive(1, 2'b01, 2'b01, 1, 0, 16'h0);
    chk("burst8 m0 grant", 32'(o_grant), 32'h1);
    chk("burst8 m0 ack", 32'(m_ack), 32'h1);
    chk("burst8 m0 flag", 32'(s_8_burst), 32'h0);
    tick();
    m_8_burst = 2'b00;
    drive(1, 2'b00, 2'b00, 0, 0, 16'h0);
    tick();

    // Watchdog: no ack, single err pulse 10 cycles into the stall
    drive(0, 2'b00, 2'b00, 0, 0, 16'h0);
    tick();
    drive(1, 2'b01, 2'b01, 0, 0, 16'h0);
    tick();
    for (int k = 0; k < 13; k++) begin
      drive(1, 2'b01, 2'b01, 0, 0, 16'h0);
      chk($sformatf("wdog k%0d err", k), 32'(m_err), (k == 10) ? 32'h1 : 32'h0);
      tick();
    end
    drive(1, 2'b00, 2'b00, 0, 0, 16'h0);
    tick();
    drive(1, 2'b00, 2'b00, 0, 0, 16'h0);
    tick();

    // Ack on the timeout cycle suppresses the err pulse
    drive(1, 2'b01, 2'b01, 0, 0, 16'h0);
    tick();
    for (int k = 0; k < 12; k++) begin
      drive(1, 2'b01, 2'b01, (k == 10), 0, 16'h0);
      chk($sformatf("wdack k%0d ack", k), 32'(m_ack), (k == 10) ? 32'h1 : 32'h0);
      chk($sformatf("wdack k%0d err", k), 32'(m_err), 32'h0);
      tick();
    end
    drive(1, 2'b00, 2'b00, 0, 0, 16'h0);
    tick();
    drive(1, 2'b00, 2'b00, 0, 0, 16'h0);
    tick();

    // Reset in the middle of a 4-beat burst owned by m0
    m_4_burst = 2'b01;
    drive(1, 2'b01, 2'b01, 0, 0, 16'h0);
    tick();
    for (int b = 0; b < 2; b++) begin
      drive(1, 2'b01, 2'b01, 1, 0, 16'h0);
      chk($sformatf("burst4 beat%0d ack", b), 32'(m_ack), 32'h1);
      chk($sformatf("burst4 beat%0d flag", b), 32'(s_4_burst), 32'h1);
      tick();
    end
    drive(0, 2'b01, 2'b01, 1, 0, 16'h0);
    chk("burst4 pre-reset grant", 32'(o_grant), 32'h1);
    tick();
    drive(1, 2'b11, 2'b11, 1, 0, 16'h0);
    chk("rst s_cyc", 32'(s_cyc), 32'h0);
    chk("rst grant", 32'(o_grant), 32'h0);
    chk("rst busy", 32'(o_busy), 32'h0);
    chk("rst ack", 32'(m_ack), 32'h0);
    chk("rst flag", 32'(s_4_burst), 32'h0);
    tick();
    drive(1, 2'b11, 2'b11, 0, 0, 16'h0);
    chk("post-rst grant", 32'(o_grant), 32'h1);
    tick();
    m_4_burst = 2'b00;
    drive(1, 2'b00, 2'b00, 0, 0, 16'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
